// File: rtl/switches_pio_debounced.sv
// rtl/switches_pio_debounced.sv - debounced WIDTH-bit input PIO with edge capture and maskable irq
module switches_pio_debounced #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 20,
    parameter int DEB_RESET   = 50000,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] agree;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [DEB_W-1:0] period;
    logic [DEB_W-1:0] period_m1;
    logic [DEB_W-1:0] cnt;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             wr_period;
    logic             wr_mask;
    logic             wr_edge;
    logic             bypass;
    logic             tick;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign wr_en     = chipselect & ~write_n;
    assign wr_period = wr_en && (address == 2'd1);
    assign wr_mask   = wr_en && (address == 2'd2);
    assign wr_edge   = wr_en && (address == 2'd3);
    assign bypass    = (period == '0);
    assign period_m1 = period - DEB_W'(1);
    // A PERIOD write restarts the prescaler, so it must not also fire a tick.
    assign tick      = !bypass && !wr_period && (cnt == period_m1);
    assign agree     = ~(sync ^ samp);
    assign clr       = wr_edge ? writedata[WIDTH-1:0] : '0;
    assign irq       = |(edge_cap & mask);

    always_comb begin
        stable_nxt = stable;
        if (bypass)
            stable_nxt = sync;
        else if (tick)
            stable_nxt = (stable & ~agree) | (sync & agree);
    end

    always_comb begin
        det = stable ^ stable_d;
        if (EDGE_MODE == 0)
            det = stable & ~stable_d;
        else if (EDGE_MODE == 1)
            det = ~stable & stable_d;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: rd_mux[DEB_W-1:0] = period;
            2'd2: rd_mux[WIDTH-1:0] = mask;
            default: rd_mux[WIDTH-1:0] = edge_cap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            samp     <= '0;
            stable   <= '0;
            stable_d <= '0;
            edge_cap <= '0;
            mask     <= '0;
            cnt      <= '0;
            period   <= DEB_W'(DEB_RESET);
            readdata <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
            stable   <= stable_nxt;
            stable_d <= stable;
            // Set wins over a same-cycle W1C clear.
            edge_cap <= (edge_cap & ~clr) | det;
            readdata <= rd_mux;
            if (tick)
                samp <= sync;
            if (wr_period || bypass || tick)
                cnt <= '0;
            else
                cnt <= cnt + DEB_W'(1);
            if (wr_period)
                period <= writedata[DEB_W-1:0];
            if (wr_mask)
                mask <= writedata[WIDTH-1:0];
        end
    end

endmodule

// File: doc/switches_pio_debounced.md
# switches_pio_debounced

Parametrised Avalon-MM input PIO: the generalised replacement for the fixed 10-bit switch port. It synchronises and debounces `WIDTH` asynchronous inputs, captures per-bit edges, and raises a maskable interrupt. It sits on the Qsys system interconnect as a slave with read latency 1, and feeds the Nios II IRQ controller through `irq`.

## Interface
- `WIDTH`, 10: number of input channels, 1..32.
- `SYNC_STAGES`, 2: synchroniser depth, at least 2.
- `DEB_W`, 20: width of the debounce prescaler and of the period register, at most 32.
- `DEB_RESET`, 50000: reset value of the debounce period register.
- `EDGE_MODE`, 0: edge type that sets capture bits. 0 = rising, 1 = falling, 2 = any.

- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `in_port` in WIDTH: asynchronous channel inputs.
- `irq` out 1: level interrupt.

## Operation
- Register map (bits above the field width read 0; writes to them are ignored):
  - 0 DATA, RO: debounced value `stable[WIDTH-1:0]`.
  - 1 PERIOD, RW: `period[DEB_W-1:0]`.
  - 2 IRQMASK, RW: `mask[WIDTH-1:0]`.
  - 3 EDGECAP, R/W1C: `edge[WIDTH-1:0]`.
- A write occurs on a cycle with `chipselect=1` and `write_n=0`. Writes to DATA have no effect.
- Synchroniser: `SYNC_STAGES` flops per bit. Its last stage is `sync`.
- Prescaler `cnt` and `tick`:
  - If `period>=1`: `tick=1` when `cnt==period-1`; on that cycle `cnt<=0`, otherwise `cnt<=cnt+1`.
  - Any write to PERIOD forces `cnt<=0` on the same edge, with no tick on that cycle.
  - If `period==0`: bypass. `tick` is ignored, `stable<=sync` every cycle, and `cnt` is held at 0.
- Debounce, when `period>=1`: each tick does `samp<=sync`, and `stable[i]<=sync[i]` when `sync[i]==samp[i]`. A level must therefore be seen on two consecutive ticks before it is accepted.
- Edge detect: `stable_d<=stable` every cycle.
  - Rise: `stable & ~stable_d`. Fall: `~stable & stable_d`.
  - Per cycle: `edge <= (edge & ~clr) | det`, where `clr = writedata[WIDTH-1:0]` on an EDGECAP write and 0 otherwise, and `det` is the event selected by `EDGE_MODE`.
  - If set and clear hit the same bit on the same cycle, the set wins.
- `irq = |(edge & mask)`, combinational from registers only, with no input-to-output path.
- Read: every cycle `readdata <= zero-extended mux(address)`, regardless of `chipselect`. Reads have no side effects.
- Reset values: `readdata=0`, `irq=0`, `stable=stable_d=samp=sync chain=0`, `edge=0`, `mask=0`, `cnt=0`, `period=DEB_RESET`.
  - Inputs high at reset are accepted after debounce and produce a rising edge.
- Reset asserted mid-operation clears all state immediately, asynchronously. Outputs are at reset values while `reset_n=0`.

## Timing
- Read latency is 1. Address presented at edge N gives data valid after edge N+1. There are no wait states.
- Bypass path, for an `in_port` change set up before edge 1:
  - `sync` updates at edge S (`S=SYNC_STAGES`).
  - `stable` updates at edge S+1.
  - `edge` and `irq` update at edge S+2.
  - `readdata` for DATA reflects the change after edge S+2.
- Debounced path: `stable` changes on the second tick at which `sync` holds the new level. Worst case is `2*period + S + 1` cycles after the input settles.
- Register writes take effect at the write edge. A read of the same address on the next cycle returns the new value.
- EDGECAP clear takes effect at the write edge; `irq` deasserts in the same cycle unless another masked bit is still set.

## Test plan
- Reset: hold `reset_n=0` with `in_port=0x3FF`, then read registers 0..3. Required: 0x0, 0xC350, 0x0, 0x0 respectively, and `irq=0`.
- Bypass latency: write PERIOD=0, then toggle `in_port[3]` 0→1. Required: DATA bit 3 readable S+2 cycles later; EDGECAP=0x008; `irq` rises only after IRQMASK=0x008 is written.
- Debounce:
  - Setup: PERIOD=4, and `in_port[0]` pulses high for 3 cycles. Required: DATA stays 0 and no edge is captured.
  - Then hold `in_port[0]` high. Required: DATA[0]=1 within 8+S+1 cycles.
- EDGE_MODE=2, IRQMASK=0x3FF, bit 5 toggles 1→0. Required: EDGECAP=0x020 and `irq=1`. Writing 0x020 to EDGECAP gives EDGECAP=0 and `irq=0` after the write edge.
- Simultaneous set and clear: an EDGECAP write of 0x001 on the same cycle that a new edge on bit 0 is detected. Required: EDGECAP reads 0x001 and `irq` stays asserted.
- Mid-operation reset: assert `reset_n` while the prescaler is counting and EDGECAP=0x0FF. Required: all outputs are 0 immediately, and PERIOD reads 0xC350 after release.
